// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one fifo write port among NUM_REQ producers.
// Every write is tagged {requester id, last, payload} so the consumer can demultiplex.
module fifo_wr_arbiter #(
    parameter int unsigned  NUM_REQ    = 4,
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  MAX_BURST  = 16,
    localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]            s_last,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic                          fifo_wr,
    output logic [ID_W+DATA_WIDTH:0]      fifo_data,
    input  logic                          fifo_full,
    output logic                          o_busy,
    output logic [ID_W-1:0]               o_grant_id
);

    localparam int unsigned      CNT_W  = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  IdMax  = ID_W'(NUM_REQ - 1);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                  any_valid;
    logic [ID_W-1:0]       winner;
    logic [ID_W-1:0]       cand;
    logic [31:0]           idx;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  g_valid;
    logic                  g_last;
    logic                  cut;

    // First requester with s_valid set, searching upward from ptr_q with wrap-around.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        idx       = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx  = (32'(ptr_q) + k) % NUM_REQ;
            cand = ID_W'(idx);
            if (!any_valid && s_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    assign g_data  = s_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign g_valid = s_valid[grant_q];
    assign g_last  = s_last[grant_q];
    assign cut     = (cnt_q == CntMax);

    assign fifo_data  = {grant_q, g_last || cut, g_data};
    assign o_busy     = (state_q == StLocked);
    assign o_grant_id = grant_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        s_ready = '0;
        fifo_wr = 1'b0;
        case (state_q)
            StIdle: begin
                if (any_valid) begin
                    grant_d = winner;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                s_ready[grant_q] = !fifo_full;
                fifo_wr          = g_valid && !fifo_full;
                if (fifo_wr) begin
                    if (g_last || cut) begin
                        state_d = StIdle;
                        ptr_d   = (grant_q == IdMax) ? '0 : grant_q + 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // A beat presented during reset is dropped rather than written.
        if (reset) begin
            s_ready = '0;
            fifo_wr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
